vram_text_writer: RTL

- Character-stream writer into the text VRAM scanned by the LCD block.
- CPU/UART side pushes one byte per valid/ready handshake.
- The block maintains a cursor and writes printable characters into VRAM port A.
- It handles control codes, line wrap and hardware scroll by VRAM copy.

---
 rtl/lcd_text_pkg.sv | 31 +++
 rtl/text_cursor.sv | 72 +++++++
 rtl/vram_text_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_pkg.sv
// Shared definitions for the LCD text path: screen geometry defaults, VRAM
// address width, control-code bytes and the text writer FSM state encoding.
// Optional build macro: VRAM_CLEAR_ON_RESET_EN adds the CLEAR state.
package lcd_text_pkg;

    localparam int unsigned COLS_DEF = 60;  // 480 px / 8 px font
    localparam int unsigned ROWS_DEF = 17;  // 272 px / 16 px font
    localparam int unsigned ADDR_W   = 10;  // VRAM depth 1024
    localparam int unsigned COL_W    = 6;
    localparam int unsigned ROW_W    = 5;

    localparam logic [7:0] FILL_DEF = 8'h20;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PUT,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_FILL
`ifdef VRAM_CLEAR_ON_RESET_EN
        , ST_CLEAR
`endif
    } state_t;

endpackage

// File: rtl/text_cursor.sv
// Text cursor: column/row counters with wrap, line advance and backspace,
// plus the linear VRAM address row*COLS+col of the current position.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (cursor to 0/0)
//   home             cursor to 0/0
//   cr               column to 0
//   lf               column to 0, next row
//   bs               column - 1 unless already 0
//   adv              column + 1, wrapping onto the next row
//   col, row         registered cursor position
//   addr_c           row*COLS+col
//   scroll_c         the current command would advance past the last row
//   col_zero_c       column is 0
module text_cursor
    import lcd_text_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              home,
    input  logic              cr,
    input  logic              lf,
    input  logic              bs,
    input  logic              adv,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr_c,
    output logic              scroll_c,
    output logic              col_zero_c
);

    logic last_col_c;
    logic last_row_c;

    assign last_col_c = (col == COL_W'(COLS - 1));
    assign last_row_c = (row == ROW_W'(ROWS - 1));
    assign col_zero_c = (col == '0);
    assign addr_c     = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

    // On the last row the row counter holds; the scroll makes room instead.
    assign scroll_c = last_row_c && (lf || (adv && last_col_c));

    // Position update, one command per cycle at most.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (home) begin
            col <= '0;
            row <= '0;
        end else if (lf || cr) begin
            col <= '0;
            if (lf && !last_row_c) begin
                row <= row + ROW_W'(1);
            end
        end else if (adv) begin
            if (last_col_c) begin
                col <= '0;
                if (!last_row_c) begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end else if (bs && !col_zero_c) begin
            col <= col - COL_W'(1);
        end
    end

endmodule

// File: rtl/vram_text_writer.sv
// Character-stream writer into the text VRAM scanned by the LCD block.
// Accepts one byte per valid/ready handshake, writes printable bytes at the
// cursor, handles LF/CR/BS/FF and scrolls by copying VRAM rows upward.
// Optional build macro: VRAM_CLEAR_ON_RESET_EN clears the screen after reset.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   ch_valid, ch_data      incoming character byte
//   ch_ready               byte accepted this cycle when valid is high
//   v_ada, v_dina, v_wea   VRAM port A address / write data / write enable
//   v_douta                VRAM port A read data (1 cycle read latency)
//   cursor_col, cursor_row current cursor position
//   busy                   scroll or clear in progress
module vram_text_writer
    import lcd_text_pkg::*;
#(
    parameter int unsigned COLS      = COLS_DEF,
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter logic [7:0]  FILL_CHAR = FILL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    output logic              ch_ready,
    output logic [ADDR_W-1:0] v_ada,
    output logic [7:0]        v_dina,
    output logic              v_wea,
    input  logic [7:0]        v_douta,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST   = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_A  = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(ROWS * COLS - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;      // scroll destination / fill address
    logic [7:0]        dina_q;
    logic              put_adv;  // PUT advances the cursor (not a backspace erase)

    logic              accept_c;
    logic              cmd_lf_c;
    logic              cmd_cr_c;
    logic              cmd_bs_c;
    logic              cmd_ff_c;
    logic              cmd_adv_c;
    logic [ADDR_W-1:0] addr_c;
    logic              scroll_c;
    logic              col_zero_c;

    assign accept_c  = (state == ST_IDLE) && ch_valid && ch_ready;
    assign cmd_lf_c  = accept_c && (ch_data == CH_LF);
    assign cmd_cr_c  = accept_c && (ch_data == CH_CR);
    assign cmd_bs_c  = accept_c && (ch_data == CH_BS);
    assign cmd_ff_c  = accept_c && (ch_data == CH_FF);
    assign cmd_adv_c = (state == ST_PUT) && put_adv;

    // The copy writes the byte read back in the previous cycle; with a
    // one-cycle read latency it is only available combinationally here.
    assign v_dina = (state == ST_SCROLL_WR) ? v_douta : dina_q;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .home       (cmd_ff_c),
        .cr         (cmd_cr_c),
        .lf         (cmd_lf_c),
        .bs         (cmd_bs_c),
        .adv        (cmd_adv_c),
        .col        (cursor_col),
        .row        (cursor_row),
        .addr_c     (addr_c),
        .scroll_c   (scroll_c),
        .col_zero_c (col_zero_c)
    );

    // Control FSM; outputs describe the cycle spent in the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            ch_ready <= 1'b0;
            v_ada    <= '0;
            dina_q   <= '0;
            v_wea    <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            put_adv  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
`ifdef VRAM_CLEAR_ON_RESET_EN
                    state  <= ST_CLEAR;
                    busy   <= 1'b1;
                    ptr    <= '0;
                    v_ada  <= '0;
                    v_wea  <= 1'b1;
                    dina_q <= FILL_CHAR;
`else
                    state    <= ST_IDLE;
                    ch_ready <= 1'b1;
`endif
                end

                ST_IDLE: begin
                    if (accept_c) begin
                        ch_ready <= 1'b0;
                        case (ch_data)
                            CH_LF: begin
                                if (scroll_c) begin
                                    state <= ST_SCROLL_RD;
                                    busy  <= 1'b1;
                                    ptr   <= '0;
                                    v_ada <= COLS_A;
                                end
                            end
                            CH_CR: ;
                            CH_BS: begin
                                // Cursor steps back this edge; erase the cell it lands on.
                                if (!col_zero_c) begin
                                    state   <= ST_PUT;
                                    put_adv <= 1'b0;
                                    v_ada   <= addr_c - ADDR_W'(1);
                                    dina_q  <= FILL_CHAR;
                                    v_wea   <= 1'b1;
                                end
                            end
                            CH_FF: begin
                                state  <= ST_FILL;
                                busy   <= 1'b1;
                                ptr    <= '0;
                                v_ada  <= '0;
                                dina_q <= FILL_CHAR;
                                v_wea  <= 1'b1;
                            end
                            default: begin
                                state   <= ST_PUT;
                                put_adv <= 1'b1;
                                v_ada   <= addr_c;
                                dina_q  <= ch_data;
                                v_wea   <= 1'b1;
                            end
                        endcase
                    end else begin
                        ch_ready <= 1'b1;
                    end
                end

                ST_PUT: begin
                    v_wea <= 1'b0;
                    if (put_adv && scroll_c) begin
                        state <= ST_SCROLL_RD;
                        busy  <= 1'b1;
                        ptr   <= '0;
                        v_ada <= COLS_A;
                    end else begin
                        state    <= ST_IDLE;
                        ch_ready <= 1'b1;
                    end
                end

                ST_SCROLL_RD: begin
                    state <= ST_SCROLL_WR;
                    v_ada <= ptr;
                    v_wea <= 1'b1;
                end

                ST_SCROLL_WR: begin
                    if (ptr == COPY_LAST) begin
                        state  <= ST_FILL;
                        ptr    <= LAST_ROW_A;
                        v_ada  <= LAST_ROW_A;
                        dina_q <= FILL_CHAR;
                        v_wea  <= 1'b1;
                    end else begin
                        state <= ST_SCROLL_RD;
                        ptr   <= ptr + ADDR_W'(1);
                        v_ada <= ptr + COLS_A + ADDR_W'(1);
                        v_wea <= 1'b0;
                    end
                end

`ifdef VRAM_CLEAR_ON_RESET_EN
                ST_CLEAR,
`endif
                ST_FILL: begin
                    // Fill always runs up to the last screen cell.
                    if (ptr == SCREEN_LAST) begin
                        state    <= ST_IDLE;
                        v_wea    <= 1'b0;
                        busy     <= 1'b0;
                        ch_ready <= 1'b1;
                    end else begin
                        ptr   <= ptr + ADDR_W'(1);
                        v_ada <= ptr + ADDR_W'(1);
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    v_wea    <= 1'b0;
                    busy     <= 1'b0;
                    ch_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
